// File: rtl/e_mdu_pkg.sv
// Shared md_op encodings for the execute-stage multiply/divide unit.
package e_mdu_pkg;

   typedef enum logic [3:0] {
      MdNone  = 4'd0,
      MdMult  = 4'd1,
      MdMultu = 4'd2,
      MdDiv   = 4'd3,
      MdDivu  = 4'd4,
      MdMthi  = 4'd5,
      MdMtlo  = 4'd6,
      MdMfhi  = 4'd7,
      MdMflo  = 4'd8
   } md_op_e;

   // Controller-side decode: ops that occupy the unit for more than one cycle.
   function automatic logic md_is_multicycle(input logic [3:0] op);
      return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
   endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO, computes results at start and
// commits them after a fixed busy window that models multiplier/divider latency.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       md_op,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic [WIDTH-1:0] md_out
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
   localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
   localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             p_wr_q, p_wr_d;

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   abs1, abs2, den_s, den_u;
   logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic               neg1, neg2, div_zero, accept;

   assign busy   = (cnt_q != '0);
   assign md_out = (md_op == MdMfhi) ? hi_q : lo_q;
   assign accept = start && !busy;

   // Signed product: low 2W bits of the sign-extended operands' product.
   assign prod_s = {{WIDTH{data1[WIDTH-1]}}, data1} * {{WIDTH{data2[WIDTH-1]}}, data2};
   assign prod_u = {{WIDTH{1'b0}}, data1} * {{WIDTH{1'b0}}, data2};

   // Signed divide via magnitudes; min_int / -1 falls out as lo=min_int, hi=0.
   assign neg1     = data1[WIDTH-1];
   assign neg2     = data2[WIDTH-1];
   assign abs1     = neg1 ? (~data1 + 1'b1) : data1;
   assign abs2     = neg2 ? (~data2 + 1'b1) : data2;
   assign div_zero = (data2 == '0);
   assign den_s    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs2;
   assign den_u    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : data2;
   assign q_mag    = abs1 / den_s;
   assign r_mag    = abs1 % den_s;
   assign q_s      = (neg1 ^ neg2) ? (~q_mag + 1'b1) : q_mag;
   assign r_s      = neg1 ? (~r_mag + 1'b1) : r_mag;
   assign q_u      = data1 / den_u;
   assign r_u      = data1 % den_u;

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      p_hi_d = p_hi_q;
      p_lo_d = p_lo_q;
      p_wr_d = p_wr_q;
      cnt_d  = cnt_q;
      if (busy) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CntW'(1) && p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
         end
      end else if (accept) begin
         case (md_op_e'(md_op))
            MdMult: begin
               {p_hi_d, p_lo_d} = prod_s;
               p_wr_d = 1'b1;
               cnt_d  = MultCnt;
            end
            MdMultu: begin
               {p_hi_d, p_lo_d} = prod_u;
               p_wr_d = 1'b1;
               cnt_d  = MultCnt;
            end
            MdDiv: begin
               p_lo_d = q_s;
               p_hi_d = r_s;
               p_wr_d = !div_zero;
               cnt_d  = DivCnt;
            end
            MdDivu: begin
               p_lo_d = q_u;
               p_hi_d = r_u;
               p_wr_d = !div_zero;
               cnt_d  = DivCnt;
            end
            MdMthi:  hi_d = data1;
            MdMtlo:  lo_d = data1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         p_hi_q <= '0;
         p_lo_q <= '0;
         p_wr_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         p_hi_q <= p_hi_d;
         p_lo_q <= p_lo_d;
         p_wr_q <= p_wr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  md_op = MdMflo;
   logic [31:0] data1 = '0;
   logic [31:0] data2 = '0;
   logic        busy;
   logic [31:0] md_out;

   int n_tests = 0;
   int n_fail  = 0;

   e_mdu #(
      .WIDTH      (32),
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .data1 (data1),
      .data2 (data2),
      .busy  (busy),
      .md_out(md_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      md_op = MdMfhi;
      #1;
      check_eq({tag, " hi"}, md_out, exp_hi);
      md_op = MdMflo;
      #1;
      check_eq({tag, " lo"}, md_out, exp_lo);
   endtask

   // Issue one op and count busy cycles (bounded); returns in the first non-busy cycle.
   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] old_lo);
      int busy_cnt;
      start = 1'b1;
      md_op = op;
      data1 = a;
      data2 = b;
      tick();
      start = 1'b0;
      md_op = MdMflo;
      #1;
      check_eq({tag, " old lo while busy"}, md_out, old_lo);
      busy_cnt = 0;
      for (int i = 0; i < n + 3; i++) begin
         if (!busy) break;
         busy_cnt++;
         tick();
      end
      check_eq({tag, " busy cycles"}, busy_cnt, n);
   endtask

   initial begin
      tick();
      tick();
      check_eq("reset busy", {31'b0, busy}, 32'h0);
      read_hilo("reset", 32'h0, 32'h0);
      reset = 1'b0;
      tick();

      // 1: signed mult -2 x 3
      run_md("mult", MdMult, 32'hFFFF_FFFE, 32'h3, 5, 32'h0);
      read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // 2: unsigned mult
      run_md("multu", MdMultu, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFA);
      read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

      // 3: signed div truncates toward zero; divu by zero leaves HI/LO alone
      run_md("div", MdDiv, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFE);
      read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu0", MdDivu, 32'h7, 32'h0, 10, 32'hFFFF_FFFD);
      read_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divovf", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFD);
      read_hilo("divovf", 32'h0, 32'h8000_0000);
      run_md("divu", MdDivu, 32'd100, 32'd7, 10, 32'h8000_0000);
      read_hilo("divu", 32'd2, 32'd14);

      // 4: mtlo then mflo next cycle, no busy
      start = 1'b1;
      md_op = MdMtlo;
      data1 = 32'h1234;
      tick();
      start = 1'b0;
      md_op = MdMflo;
      #1;
      check_eq("mtlo busy", {31'b0, busy}, 32'h0);
      check_eq("mtlo mflo", md_out, 32'h1234);

      // undefined op: no effect
      start = 1'b1;
      md_op = 4'hF;
      data1 = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      check_eq("undef busy", {31'b0, busy}, 32'h0);
      read_hilo("undef", 32'd2, 32'h1234);

      // 5: mthi during busy cycle 4 of a div is ignored
      start = 1'b1;
      md_op = MdDiv;
      data1 = 32'd23;
      data2 = 32'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check_eq("ign busy c4", {31'b0, busy}, 32'h1);
      start = 1'b1;
      md_op = MdMthi;
      data1 = 32'hAAAA;
      tick();
      start = 1'b0;
      md_op = MdMflo;
      for (int i = 0; i < 5; i++) tick();
      check_eq("ign busy c10", {31'b0, busy}, 32'h1);
      tick();
      check_eq("ign done", {31'b0, busy}, 32'h0);
      read_hilo("ign", 32'd3, 32'd4);

      // 6: reset at busy cycle 3 of a mult abandons it
      start = 1'b1;
      md_op = MdMult;
      data1 = 32'd3;
      data2 = 32'd4;
      tick();
      start = 1'b0;
      md_op = MdMflo;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_eq("rst busy", {31'b0, busy}, 32'h0);
      read_hilo("rst", 32'h0, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check_eq("rst idle", {31'b0, busy}, 32'h0);
      read_hilo("rst idle", 32'h0, 32'h0);
      run_md("post", MdMult, 32'd5, 32'hFFFF_FFFA, 5, 32'h0);
      read_hilo("post", 32'hFFFF_FFFF, 32'hFFFF_FFE2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
